// File: rtl/pcie_tx_arbiter_pkg.sv
// rtl/pcie_tx_arbiter_pkg.sv - shared types for the PCIe TX TLP arbiter
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER_PIO,
        XFER_INJ
    } arb_state_t;

    localparam int SRC_PIO = 0;
    localparam int SRC_INJ = 1;

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// rtl/pcie_tx_arbiter_if.sv - TLP stream bundle between sources, arbiter and PCIe core
interface pcie_tx_arbiter_if #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [KEEP_WIDTH-1:0]   tkeep;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic [3:0]              tuser;

    modport master (output tvalid, tlast, tkeep, tdata, tuser, input tready);
    modport slave  (input tvalid, tlast, tkeep, tdata, tuser, output tready);
endinterface

// File: rtl/pcie_tx_arbiter_stat_cnt32.sv
// rtl/pcie_tx_arbiter_stat_cnt32.sv - 32-bit wrapping event counter for debug registers
module stat_cnt32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - round-robin TLP arbiter merging PIO and injection streams onto the core TX
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int         C_DATA_WIDTH = 64,
    parameter int         KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter logic [5:0] MIN_BUF_AV   = 6'd2
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_rst_n,
    input  logic                  pcie_tx_req,
    output logic                  pcie_tx_ack,
    pcie_tx_arbiter_if.slave      pcie_tx,
    pcie_tx_arbiter_if.slave      pcie_tx1,
    pcie_tx_arbiter_if.master     s_axis_tx,
    input  logic [5:0]            tx_buf_av,
    output logic [31:0]           cnt_pio,
    output logic [31:0]           cnt_inj,
    output logic [31:0]           cnt_stall
);

    arb_state_t              state;
    logic                    prio;
    logic [1:0]              req;
    logic                    buf_ok;
    logic                    pick_inj;
    logic                    tlp_done;

    logic                    mux_tvalid;
    logic                    mux_tlast;
    logic [KEEP_WIDTH-1:0]   mux_tkeep;
    logic [C_DATA_WIDTH-1:0] mux_tdata;
    logic [3:0]              mux_tuser;
    logic                    pio_tready;
    logic                    inj_tready;

    assign req[SRC_PIO] = pcie_tx_req;
    assign req[SRC_INJ] = pcie_tx1.tvalid;
    assign buf_ok       = (tx_buf_av >= MIN_BUF_AV);
    // Injection wins when alone, or when both pend and prio points at it.
    assign pick_inj     = req[SRC_INJ] & (~req[SRC_PIO] | prio);

    // Zero-latency data path; the idle state presents an empty bus.
    always_comb begin
        mux_tvalid = 1'b0;
        mux_tlast  = 1'b0;
        mux_tkeep  = '0;
        mux_tdata  = '0;
        mux_tuser  = '0;
        pio_tready = 1'b0;
        inj_tready = 1'b0;
        case (state)
            XFER_PIO: begin
                mux_tvalid = pcie_tx.tvalid;
                mux_tlast  = pcie_tx.tlast;
                mux_tkeep  = pcie_tx.tkeep;
                mux_tdata  = pcie_tx.tdata;
                mux_tuser  = pcie_tx.tuser;
                pio_tready = s_axis_tx.tready;
            end
            XFER_INJ: begin
                mux_tvalid = pcie_tx1.tvalid;
                mux_tlast  = pcie_tx1.tlast;
                mux_tkeep  = pcie_tx1.tkeep;
                mux_tdata  = pcie_tx1.tdata;
                mux_tuser  = pcie_tx1.tuser;
                inj_tready = s_axis_tx.tready;
            end
            default: ;
        endcase
    end

    assign s_axis_tx.tvalid = mux_tvalid;
    assign s_axis_tx.tlast  = mux_tlast;
    assign s_axis_tx.tkeep  = mux_tkeep;
    assign s_axis_tx.tdata  = mux_tdata;
    assign s_axis_tx.tuser  = mux_tuser;
    assign pcie_tx.tready   = pio_tready;
    assign pcie_tx1.tready  = inj_tready;

    assign tlp_done = mux_tvalid & s_axis_tx.tready & mux_tlast;

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            pcie_tx_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Buffer level only gates new grants; a TLP in flight always finishes.
                    if ((|req) && buf_ok) begin
                        if (pick_inj) begin
                            state <= XFER_INJ;
                        end else begin
                            state       <= XFER_PIO;
                            pcie_tx_ack <= 1'b1;
                        end
                    end
                end
                XFER_PIO: begin
                    if (tlp_done) begin
                        state       <= IDLE;
                        pcie_tx_ack <= 1'b0;
                        prio        <= 1'b1;
                    end
                end
                XFER_INJ: begin
                    if (tlp_done) begin
                        state <= IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pcie_tx_ack <= 1'b0;
                end
            endcase
        end
    end

    stat_cnt32 u_cnt_pio (
        .clk   (pcie_clk),
        .rst_n (pcie_rst_n),
        .en    ((state == XFER_PIO) && tlp_done),
        .cnt   (cnt_pio)
    );

    stat_cnt32 u_cnt_inj (
        .clk   (pcie_clk),
        .rst_n (pcie_rst_n),
        .en    ((state == XFER_INJ) && tlp_done),
        .cnt   (cnt_inj)
    );

    stat_cnt32 u_cnt_stall (
        .clk   (pcie_clk),
        .rst_n (pcie_rst_n),
        .en    ((state == IDLE) && (|req) && !buf_ok),
        .cnt   (cnt_stall)
    );

endmodule
